tnoc_packet_unpacker_vc: RTL

TNOC_PACKET_UNPACKER_VC -- requirements
Module: tnoc_packet_unpacker_vc

---
 rtl/tnoc_packet_unpacker_vc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tnoc_packet_unpacker_vc.sv
// rtl/tnoc_packet_unpacker_vc.sv - per-VC flit-to-packet unpacker: reassembles header flits and forwards payload
// Each virtual channel keeps its own context, so flits of different VCs may interleave freely.
module tnoc_packet_unpacker_vc #(
  parameter int CHANNELS              = 2,
  parameter int FLIT_DATA_WIDTH       = 32,
  parameter int REQUEST_HEADER_FLITS  = 3,
  parameter int RESPONSE_HEADER_FLITS = 2,
  parameter int HEADER_FLITS          = (REQUEST_HEADER_FLITS > RESPONSE_HEADER_FLITS) ?
                                        REQUEST_HEADER_FLITS : RESPONSE_HEADER_FLITS,
  parameter int VC_WIDTH              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_flit_valid,
  output logic                                    o_flit_ready,
  input  logic [VC_WIDTH-1:0]                     i_flit_vc,
  input  logic                                    i_flit_header,
  input  logic                                    i_flit_tail,
  input  logic [FLIT_DATA_WIDTH-1:0]              i_flit_data,
  output logic                                    o_header_valid,
  input  logic                                    i_header_ready,
  output logic [VC_WIDTH-1:0]                     o_header_vc,
  output logic [HEADER_FLITS*FLIT_DATA_WIDTH-1:0] o_header_data,
  output logic                                    o_header_only,
  output logic                                    o_payload_valid,
  input  logic                                    i_payload_ready,
  output logic [VC_WIDTH-1:0]                     o_payload_vc,
  output logic [FLIT_DATA_WIDTH-1:0]              o_payload_data,
  output logic                                    o_payload_last,
  output logic                                    o_payload_type,
  output logic                                    o_error
);

  localparam int CNT_W = $clog2(HEADER_FLITS) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQUEST_HEADER_FLITS - 1);
  localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(RESPONSE_HEADER_FLITS - 1);

  logic [1:0]       state   [CHANNELS];
  logic [CNT_W-1:0] count   [CHANNELS];
  logic             ptype   [CHANNELS];
  logic             error_q;

  logic                vc_ok;
  logic [VC_WIDTH-1:0] vc_sel;
  logic [1:0]          cur_state;
  logic [CNT_W-1:0]    cur_count;
  logic                cur_ptype;
  logic                first_flit;
  logic                is_resp;
  logic                last_hdr;
  logic                hdr_phase_flit;
  logic                hdr_mid;
  logic                hdr_end;
  logic                pay;
  logic                err;
  logic                accept;

  // Out-of-range VC numbers (non power-of-two CHANNELS) are treated as protocol errors.
  always_comb begin
    vc_ok          = ({1'b0, i_flit_vc} < (VC_WIDTH + 1)'(CHANNELS));
    vc_sel         = vc_ok ? i_flit_vc : '0;
    cur_state      = state[vc_sel];
    cur_count      = count[vc_sel];
    cur_ptype      = ptype[vc_sel];
    first_flit     = (cur_state == ST_IDLE);
    is_resp        = first_flit ? i_flit_data[7] : cur_ptype;
    last_hdr       = (cur_count == (is_resp ? RSP_LAST : REQ_LAST));
    hdr_phase_flit = vc_ok && i_flit_header && (cur_state != ST_PAYLOAD);
    hdr_mid        = hdr_phase_flit && !last_hdr && !i_flit_tail;
    hdr_end        = hdr_phase_flit && last_hdr;
    pay            = vc_ok && !i_flit_header && (cur_state == ST_PAYLOAD);
    err            = !(hdr_mid || hdr_end || pay);
  end

  assign o_flit_ready    = hdr_end ? i_header_ready : (pay ? i_payload_ready : 1'b1);
  assign accept          = i_flit_valid && o_flit_ready;
  assign o_header_valid  = i_flit_valid && hdr_end;
  assign o_payload_valid = i_flit_valid && pay;
  assign o_header_vc     = i_flit_vc;
  assign o_payload_vc    = i_flit_vc;
  assign o_header_only   = i_flit_tail;
  assign o_payload_data  = i_flit_data;
  assign o_payload_last  = i_flit_tail;
  assign o_payload_type  = cur_ptype;
  assign o_error         = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state[ch] <= ST_IDLE;
        count[ch] <= '0;
        ptype[ch] <= 1'b0;
      end
      error_q <= 1'b0;
    end else begin
      error_q <= accept && err;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (accept && (VC_WIDTH'(ch) == vc_sel)) begin
          if (hdr_mid) begin
            state[ch] <= ST_HEADER;
            count[ch] <= cur_count + 1'b1;
            if (first_flit) ptype[ch] <= i_flit_data[7];
          end else if (hdr_end) begin
            state[ch] <= i_flit_tail ? ST_IDLE : ST_PAYLOAD;
            count[ch] <= '0;
            if (first_flit) ptype[ch] <= i_flit_data[7];
          end else if (pay) begin
            if (i_flit_tail) state[ch] <= ST_IDLE;
          end else if (vc_ok && (cur_state == ST_HEADER)) begin
            state[ch] <= ST_IDLE;
            count[ch] <= '0;
          end
        end
      end
    end
  end

  // Slots below the current count come from storage, the current flit fills the next one,
  // and anything above is forced to zero so stale data from older packets never leaks.
  if (HEADER_FLITS > 1) begin : g_buf
    logic [FLIT_DATA_WIDTH-1:0] slots [CHANNELS][HEADER_FLITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          for (int s = 0; s < HEADER_FLITS - 1; s++) begin
            slots[ch][s] <= '0;
          end
        end
      end else if (accept && hdr_mid) begin
        for (int s = 0; s < HEADER_FLITS - 1; s++) begin
          if (CNT_W'(s) == cur_count) slots[vc_sel][s] <= i_flit_data;
        end
      end
    end

    for (genvar k = 0; k < HEADER_FLITS; k++) begin : g_slot
      if (k < HEADER_FLITS - 1) begin : g_stored
        assign o_header_data[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] =
          (CNT_W'(k) < cur_count)  ? slots[vc_sel][k] :
          (CNT_W'(k) == cur_count) ? i_flit_data : '0;
      end else begin : g_top
        assign o_header_data[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] =
          (CNT_W'(k) == cur_count) ? i_flit_data : '0;
      end
    end
  end else begin : g_nobuf
    assign o_header_data = i_flit_data;
  end

endmodule
